// File: rtl/audio_mixer_dac_if.sv
// audio_mixer_dac_if: sample memory read bus between the mixer and its
// sample memory. Read data is valid exactly one clk after mem_rd.
interface audio_mixer_dac_if #(
    parameter int ADDR_W   = 15,
    parameter int SAMPLE_W = 8
);
    logic                mem_rd;
    logic [ADDR_W-1:0]   mem_addr;
    logic [SAMPLE_W-1:0] mem_data;

    modport master (
        output mem_rd,
        output mem_addr,
        input  mem_data
    );

    modport slave (
        input  mem_rd,
        input  mem_addr,
        output mem_data
    );
endinterface

// File: rtl/audio_mixer_dac.sv
// audio_mixer_dac: NUM_CH-channel PCM playback mixer feeding the codec DAC.
// Each frame (rising daclrck) every channel is fetched from the shared
// sample memory in two clks, summed with saturation, and the previous
// frame's mix is shifted out left-justified, MSB first, in both halves.
// Optional feature macro: AUDIO_MIXER_VOLUME_EN adds a per-channel 3-bit
// vol input (6 dB attenuation steps); undefined means unity gain.
module audio_mixer_dac #(
    parameter int NUM_CH   = 4,
    parameter int SAMPLE_W = 8,
    parameter int ADDR_W   = 15,
    parameter int OUT_W    = 16
) (
    input  logic                       clk,
    input  logic                       swt,
    input  logic                       bclk,
    input  logic                       daclrck,
    output logic                       dacdat,
    input  logic [NUM_CH-1:0]          trig,
    input  logic [NUM_CH*ADDR_W-1:0]   start_addr,
    input  logic [NUM_CH*ADDR_W-1:0]   length,
    input  logic [NUM_CH-1:0]          loop_en,
`ifdef AUDIO_MIXER_VOLUME_EN
    input  logic [NUM_CH*3-1:0]        vol,
`endif
    audio_mixer_dac_if.master          mem,
    output logic [NUM_CH-1:0]          busy,
    output logic [NUM_CH-1:0]          done,
    output logic signed [OUT_W-1:0]    mix_out,
    output logic                       clip
);

    localparam int ACC_W = OUT_W + 3;
    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [SAMPLE_W-1:0]     MSB_MASK = SAMPLE_W'(1) << (SAMPLE_W - 1);
    localparam logic signed [ACC_W-1:0] SAT_MAX  = {4'b0000, {(OUT_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN  = {4'b1111, {(OUT_W-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        MIX   = 2'd2
    } state_t;

    state_t              state, state_nxt;
    logic [CH_W-1:0]     ch, ch_nxt;
    logic                phase_b, phase_b_nxt;
    logic                rd_q;

    logic [2:0]          bclk_sync;
    logic [2:0]          lrck_sync;
    logic                bclk_fall;
    logic                lrck_edge;
    logic                frame_strobe;

    logic [ADDR_W-1:0]   start_q [NUM_CH];
    logic [ADDR_W-1:0]   len_q   [NUM_CH];
    logic [ADDR_W-1:0]   ptr     [NUM_CH];
    logic [ADDR_W-1:0]   rem     [NUM_CH];

    logic [SAMPLE_W-1:0] sample_signed;
    logic [OUT_W-1:0]    aligned;
    logic signed [OUT_W-1:0] scaled;
    logic signed [ACC_W-1:0] contrib;
    logic signed [ACC_W-1:0] acc;
    logic signed [OUT_W-1:0] sat;
    logic                sat_hit;

    logic [OUT_W-1:0]    hold;
    logic [OUT_W-1:0]    shreg;

    // Two-flop synchronisers for the codec clocks plus one extra stage for edge detection.
    always_ff @(posedge clk or negedge swt) begin
        if (!swt) begin
            bclk_sync <= '0;
            lrck_sync <= '0;
        end else begin
            bclk_sync <= {bclk_sync[1:0], bclk};
            lrck_sync <= {lrck_sync[1:0], daclrck};
        end
    end

    assign bclk_fall    = bclk_sync[2] & ~bclk_sync[1];
    assign lrck_edge    = lrck_sync[2] ^ lrck_sync[1];
    assign frame_strobe = lrck_sync[1] & ~lrck_sync[2];

    // Fetch FSM state register: current state, channel index and A/B phase.
    always_ff @(posedge clk or negedge swt) begin
        if (!swt) begin
            state   <= IDLE;
            ch      <= '0;
            phase_b <= 1'b0;
        end else begin
            state   <= state_nxt;
            ch      <= ch_nxt;
            phase_b <= phase_b_nxt;
        end
    end

    // Next-state logic; the memory read is issued in clk A of a busy channel.
    always_comb begin
        state_nxt    = state;
        ch_nxt       = ch;
        phase_b_nxt  = phase_b;
        mem.mem_rd   = 1'b0;
        mem.mem_addr = '0;
        case (state)
            IDLE: begin
                if (frame_strobe) begin
                    state_nxt   = FETCH;
                    ch_nxt      = '0;
                    phase_b_nxt = 1'b0;
                end
            end
            FETCH: begin
                if (!phase_b) begin
                    phase_b_nxt = 1'b1;
                    if (busy[ch]) begin
                        mem.mem_rd   = 1'b1;
                        mem.mem_addr = ptr[ch];
                    end
                end else begin
                    phase_b_nxt = 1'b0;
                    if (ch == CH_W'(NUM_CH - 1)) begin
                        state_nxt = MIX;
                    end else begin
                        ch_nxt = ch + 1'b1;
                    end
                end
            end
            MIX: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Offset-binary to signed, left-align to OUT_W, optional attenuation, sign-extend.
    always_comb begin
        sample_signed = mem.mem_data ^ MSB_MASK;
        aligned       = OUT_W'(sample_signed) << (OUT_W - SAMPLE_W);
`ifdef AUDIO_MIXER_VOLUME_EN
        scaled        = $signed(aligned) >>> vol[int'(ch)*3 +: 3];
`else
        scaled        = $signed(aligned);
`endif
        contrib       = {{3{scaled[OUT_W-1]}}, scaled};
    end

    // Saturate the wide accumulator to the signed OUT_W range.
    always_comb begin
        sat     = acc[OUT_W-1:0];
        sat_hit = 1'b0;
        if (acc > SAT_MAX) begin
            sat     = SAT_MAX[OUT_W-1:0];
            sat_hit = 1'b1;
        end else if (acc < SAT_MIN) begin
            sat     = SAT_MIN[OUT_W-1:0];
            sat_hit = 1'b1;
        end
    end

    // Accumulate fetched samples in clk B and publish the saturated mix in MIX.
    always_ff @(posedge clk or negedge swt) begin
        if (!swt) begin
            rd_q    <= 1'b0;
            acc     <= '0;
            mix_out <= '0;
            clip    <= 1'b0;
        end else begin
            rd_q <= mem.mem_rd;
            clip <= 1'b0;
            if (state == IDLE && frame_strobe) begin
                acc <= '0;
            end else if (state == FETCH && phase_b && rd_q) begin
                acc <= acc + contrib;
            end
            if (state == MIX) begin
                mix_out <= sat;
                clip    <= sat_hit;
            end
        end
    end

    // Per-channel playback state: trigger latching and pointer advance after each fetch.
    always_ff @(posedge clk or negedge swt) begin
        if (!swt) begin
            for (int i = 0; i < NUM_CH; i++) begin
                start_q[i] <= '0;
                len_q[i]   <= '0;
                ptr[i]     <= '0;
                rem[i]     <= '0;
            end
            busy <= '0;
            done <= '0;
        end else begin
            done <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                if (state == FETCH && phase_b && rd_q && ch == CH_W'(i)) begin
                    if (rem[i] == ADDR_W'(1)) begin
                        if (loop_en[i]) begin
                            ptr[i] <= start_q[i];
                            rem[i] <= len_q[i];
                        end else begin
                            ptr[i]  <= ptr[i] + 1'b1;
                            rem[i]  <= '0;
                            busy[i] <= 1'b0;
                            done[i] <= 1'b1;
                        end
                    end else begin
                        ptr[i] <= ptr[i] + 1'b1;
                        rem[i] <= rem[i] - 1'b1;
                    end
                end
                if (trig[i] && (length[i*ADDR_W +: ADDR_W] != '0)) begin
                    start_q[i] <= start_addr[i*ADDR_W +: ADDR_W];
                    len_q[i]   <= length[i*ADDR_W +: ADDR_W];
                    ptr[i]     <= start_addr[i*ADDR_W +: ADDR_W];
                    rem[i]     <= length[i*ADDR_W +: ADDR_W];
                    busy[i]    <= 1'b1;
                    done[i]    <= 1'b0;
                end
            end
        end
    end

    // Frame-hold and serializer: reload on every daclrck edge, shift on bclk falling edges.
    always_ff @(posedge clk or negedge swt) begin
        if (!swt) begin
            hold  <= '0;
            shreg <= '0;
        end else begin
            if (frame_strobe) begin
                hold  <= mix_out;
                shreg <= mix_out;
            end else if (lrck_edge) begin
                shreg <= hold;
            end else if (bclk_fall) begin
                shreg <= shreg << 1;
            end
        end
    end

    assign dacdat = shreg[OUT_W-1];

endmodule

// File: tb/tb_audio_mixer_dac.sv
// tb_audio_mixer_dac: directed, table-driven bench for audio_mixer_dac.
// Generates a free-running codec bit/word clock, models the sample memory,
// and captures each serialized half-frame for comparison.
module tb_audio_mixer_dac;

    localparam int NUM_CH   = 4;
    localparam int SAMPLE_W = 8;
    localparam int ADDR_W   = 15;
    localparam int OUT_W    = 16;

    typedef struct {
        logic [3:0]  mask;
        logic [31:0] data;
        logic [15:0] exp_mix;
        int          exp_clip;
    } vec_t;

    logic                     clk;
    logic                     swt;
    logic                     bclk;
    logic                     daclrck;
    logic                     dacdat;
    logic [NUM_CH-1:0]        trig;
    logic [NUM_CH*ADDR_W-1:0] start_addr;
    logic [NUM_CH*ADDR_W-1:0] length;
    logic [NUM_CH-1:0]        loop_en;
    logic [NUM_CH-1:0]        busy;
    logic [NUM_CH-1:0]        done;
    logic [OUT_W-1:0]         mix_out;
    logic                     clip;
`ifdef AUDIO_MIXER_VOLUME_EN
    logic [NUM_CH*3-1:0]      vol;
`endif

    logic [7:0]   mem [0:32767];
    logic [14:0]  fetch_q [$];
    logic [15:0]  cap;
    logic [15:0]  left_word;
    logic [15:0]  right_word;
    int           frames;
    int           checks;
    int           errors;
    int           clip_cnt;
    int           done0_cnt;
    int           done1_cnt;
    vec_t         vecs [9];

    audio_mixer_dac_if #(.ADDR_W(ADDR_W), .SAMPLE_W(SAMPLE_W)) bus ();

    audio_mixer_dac #(
        .NUM_CH   (NUM_CH),
        .SAMPLE_W (SAMPLE_W),
        .ADDR_W   (ADDR_W),
        .OUT_W    (OUT_W)
    ) dut (
        .clk        (clk),
        .swt        (swt),
        .bclk       (bclk),
        .daclrck    (daclrck),
        .dacdat     (dacdat),
        .trig       (trig),
        .start_addr (start_addr),
        .length     (length),
        .loop_en    (loop_en),
`ifdef AUDIO_MIXER_VOLUME_EN
        .vol        (vol),
`endif
        .mem        (bus),
        .busy       (busy),
        .done       (done),
        .mix_out    (mix_out),
        .clip       (clip)
    );

    // 50 MHz system clock.
    initial begin
        clk = 1'b0;
        forever #10 clk = ~clk;
    end

    // Codec clock generator: 16 clk bclk period, 16 bclks per half, captures dacdat on bclk rise.
    initial begin
        bclk       = 1'b1;
        daclrck    = 1'b0;
        frames     = 0;
        cap        = '0;
        left_word  = '0;
        right_word = '0;
        repeat (5) @(negedge clk);
        forever begin
            bclk = 1'b0;
            if (daclrck) left_word = cap;
            else         right_word = cap;
            daclrck = ~daclrck;
            if (daclrck) frames++;
            for (int b = 0; b < 16; b++) begin
                repeat (8) @(negedge clk);
                bclk = 1'b1;
                cap  = {cap[14:0], dacdat};
                repeat (8) @(negedge clk);
                if (b != 15) bclk = 1'b0;
            end
        end
    end

    // Sample memory: data valid one clk after the read strobe.
    always @(posedge clk) begin
        if (bus.mem_rd) bus.mem_data <= mem[bus.mem_addr];
    end

    // Event monitor sampled away from the active edge.
    always @(negedge clk) begin
        if (clip === 1'b1)    clip_cnt++;
        if (done[0] === 1'b1) done0_cnt++;
        if (done[1] === 1'b1) done1_cnt++;
        if (bus.mem_rd === 1'b1) fetch_q.push_back(bus.mem_addr);
    end

    // Global cycle budget.
    initial begin
        repeat (60000) @(posedge clk);
        $display("[TB] FAIL watchdog: cycle budget expired, got no finish, expected finish");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input int ch, input logic [14:0] st, input logic [14:0] len, input logic lp);
        start_addr[ch*ADDR_W +: ADDR_W] = st;
        length[ch*ADDR_W +: ADDR_W]     = len;
        loop_en[ch]                     = lp;
        trig[ch]                        = 1'b1;
        @(negedge clk);
        trig[ch]                        = 1'b0;
    endtask

    task automatic waitFrameEdge();
        int f;
        int k;
        f = frames;
        k = 0;
        while (frames == f && k < 2000) begin
            @(negedge clk);
            k++;
        end
        checkOutput("frame timeout", (frames != f) ? 32'd1 : 32'd0, 32'd1);
    endtask

    task automatic waitFrame();
        waitFrameEdge();
        repeat (40) @(negedge clk);
    endtask

    function automatic logic [31:0] oneFetch();
        return (fetch_q.size() == 1) ? 32'(fetch_q[0]) : 32'hFFFF_FFFF;
    endfunction

    initial begin
        int c0;
        int d1;
        int k;

        vecs[0] = '{4'b0001, 32'h0000_00C0, 16'h4000, 0};
        vecs[1] = '{4'b1111, 32'hFFFF_FFFF, 16'h7FFF, 1};
        vecs[2] = '{4'b1111, 32'h0000_0000, 16'h8000, 1};
        vecs[3] = '{4'b0011, 32'h0000_C0C0, 16'h7FFF, 1};
        vecs[4] = '{4'b0011, 32'h0000_8000, 16'h8000, 0};
        vecs[5] = '{4'b0101, 32'h0040_00C0, 16'h0000, 0};
        vecs[6] = '{4'b1111, 32'h8090_9090, 16'h3000, 0};
        vecs[7] = '{4'b0000, 32'h0000_0000, 16'h0000, 0};
        vecs[8] = '{4'b0110, 32'h007F_7F00, 16'hFE00, 0};

        checks     = 0;
        errors     = 0;
        clip_cnt   = 0;
        done0_cnt  = 0;
        done1_cnt  = 0;
        trig       = '0;
        start_addr = '0;
        length     = '0;
        loop_en    = '0;
`ifdef AUDIO_MIXER_VOLUME_EN
        vol        = '0;
`endif
        for (int a = 0; a < 32768; a++) mem[a] = 8'h80;

        swt = 1'b0;
        repeat (4) @(negedge clk);
        checkOutput("reset busy",    32'(busy),         32'h0);
        checkOutput("reset done",    32'(done),         32'h0);
        checkOutput("reset mix_out", 32'(mix_out),      32'h0);
        checkOutput("reset clip",    32'(clip),         32'h0);
        checkOutput("reset dacdat",  32'(dacdat),       32'h0);
        checkOutput("reset mem_rd",  32'(bus.mem_rd),   32'h0);
        checkOutput("reset mem_addr",32'(bus.mem_addr), 32'h0);
        swt = 1'b1;
        waitFrame();

        $display("[TB] single channel playback");
        mem[15'h0100] = 8'hC0;
        mem[15'h0101] = 8'hC0;
        mem[15'h0102] = 8'hC0;
        fetch_q.delete();
        applyStimulus(0, 15'h0100, 15'd3, 1'b0);
        for (int f = 0; f < 3; f++) begin
            waitFrame();
            checkOutput($sformatf("single fetch%0d addr", f), oneFetch(), 32'h0100 + f);
            checkOutput($sformatf("single fetch%0d mix", f), 32'(mix_out), 32'h4000);
            fetch_q.delete();
        end
        checkOutput("single left half",  32'(left_word),  32'h4000);
        checkOutput("single right half", 32'(right_word), 32'h4000);
        checkOutput("single done count", done0_cnt,       32'd1);
        checkOutput("single busy after", 32'(busy[0]),    32'h0);
        waitFrame();
        checkOutput("single idle mix",   32'(mix_out),    32'h0000);
        checkOutput("single idle fetch", fetch_q.size(),  32'd0);

`ifdef AUDIO_MIXER_VOLUME_EN
        $display("[TB] volume");
        mem[15'h1000] = 8'hC0;
        vol[2:0] = 3'd2;
        applyStimulus(0, 15'h1000, 15'd1, 1'b0);
        waitFrame();
        checkOutput("vol2 mix", 32'(mix_out), 32'h1000);
        vol[2:0] = 3'd0;
        applyStimulus(0, 15'h1000, 15'd1, 1'b0);
        waitFrame();
        checkOutput("vol0 mix", 32'(mix_out), 32'h4000);
`endif

        $display("[TB] mix vectors");
        for (int v = 0; v < 9; v++) begin
            c0 = clip_cnt;
            for (int c = 0; c < NUM_CH; c++) begin
                if (vecs[v].mask[c]) begin
                    mem[15'h1000 * (c + 1)] = vecs[v].data[c*8 +: 8];
                    applyStimulus(c, 15'(15'h1000 * (c + 1)), 15'd1, 1'b0);
                end
            end
            waitFrame();
            checkOutput($sformatf("vec%0d mix", v),  32'(mix_out),   32'(vecs[v].exp_mix));
            checkOutput($sformatf("vec%0d clip", v), clip_cnt - c0, vecs[v].exp_clip);
        end
        waitFrame();
        waitFrame();
        checkOutput("negative left half",  32'(left_word),  32'hFE00);
        checkOutput("negative right half", 32'(right_word), 32'hFE00);

        $display("[TB] zero length and retrigger");
        applyStimulus(2, 15'h0050, 15'd0, 1'b0);
        @(negedge clk);
        checkOutput("zero length busy", 32'(busy[2]), 32'h0);
        mem[15'h0201] = 8'hA0;
        fetch_q.delete();
        applyStimulus(0, 15'h0300, 15'd10, 1'b0);
        waitFrame();
        checkOutput("retrig first", oneFetch(), 32'h0300);
        fetch_q.delete();
        waitFrame();
        checkOutput("retrig second", oneFetch(), 32'h0301);
        applyStimulus(0, 15'h0200, 15'd10, 1'b0);
        fetch_q.delete();
        waitFrame();
        checkOutput("retrig new start", oneFetch(), 32'h0200);
        fetch_q.delete();
        waitFrameEdge();
        k = 0;
        while (bus.mem_rd !== 1'b1 && k < 100) begin
            @(negedge clk);
            k++;
        end
        checkOutput("clkB read seen", 32'(bus.mem_rd), 32'h1);
        @(negedge clk);
        applyStimulus(0, 15'h0400, 15'd10, 1'b0);
        repeat (40) @(negedge clk);
        checkOutput("clkB fetch addr", oneFetch(), 32'h0201);
        checkOutput("clkB sample mixed", 32'(mix_out), 32'h2000);
        checkOutput("clkB busy", 32'(busy[0]), 32'h1);
        fetch_q.delete();
        waitFrame();
        checkOutput("clkB pointer loaded", oneFetch(), 32'h0400);

        $display("[TB] loop and wrap");
        d1 = done1_cnt;
        applyStimulus(1, 15'h7FFF, 15'd2, 1'b1);
        for (int f = 0; f < 4; f++) begin
            fetch_q.delete();
            waitFrame();
            checkOutput($sformatf("loop%0d count", f), fetch_q.size(), 32'd2);
            checkOutput($sformatf("loop%0d ch0 addr", f),
                        (fetch_q.size() == 2) ? 32'(fetch_q[0]) : 32'hFFFF_FFFF, 32'h0401 + f);
            checkOutput($sformatf("loop%0d ch1 addr", f),
                        (fetch_q.size() == 2) ? 32'(fetch_q[1]) : 32'hFFFF_FFFF,
                        (f % 2 == 0) ? 32'h7FFF : 32'h0000);
            checkOutput($sformatf("loop%0d busy", f), 32'(busy[1]), 32'h1);
        end
        checkOutput("loop no done", done1_cnt - d1, 32'd0);

        $display("[TB] async reset mid-playback");
        checkOutput("pre-reset busy", 32'(busy), 32'h3);
        @(negedge clk);
        #3;
        swt = 1'b0;
        #2;
        checkOutput("async reset busy",    32'(busy),       32'h0);
        checkOutput("async reset dacdat",  32'(dacdat),     32'h0);
        checkOutput("async reset mem_rd",  32'(bus.mem_rd), 32'h0);
        checkOutput("async reset mix_out", 32'(mix_out),    32'h0);
        @(negedge clk);
        swt = 1'b1;
        fetch_q.delete();
        waitFrame();
        waitFrame();
        checkOutput("post reset fetches", fetch_q.size(), 32'd0);
        checkOutput("post reset busy",    32'(busy),      32'h0);
        checkOutput("post reset mix_out", 32'(mix_out),   32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
